// File: rtl/tlp_pkg.sv
// Shared constants and helpers for the PCIe read-completion tracker.
// Completion status codes, retirement codes and the PCIe length decode.
package tlp_pkg;

    localparam logic [2:0] CPL_SC  = 3'b000;
    localparam logic [2:0] CPL_UR  = 3'b001;
    localparam logic [2:0] CPL_CRS = 3'b010;
    localparam logic [2:0] CPL_CA  = 3'b100;

    typedef enum logic [1:0] {
        DONE_OK   = 2'b00,
        DONE_STAT = 2'b01,
        DONE_OVF  = 2'b10,
        DONE_TMO  = 2'b11
    } done_err_e;

    // PCIe length fields encode the maximum (2**len_w DW) as all-zeros.
    function automatic logic [16:0] len_decode(input logic [15:0] len, input int unsigned len_w);
        return (len == '0) ? (17'd1 << len_w) : {1'b0, len};
    endfunction

endpackage

// File: rtl/tlp_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module tlp_prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlp_rd_cpl_tracker.sv
// Tag allocator and per-tag completion tracker for outbound MRd requests.
// Retires tags on final completion, bad status, overflow or timeout onto a one-entry done register.
module tlp_rd_cpl_tracker
    import tlp_pkg::*;
#(
    parameter int TAG_W    = 3,
    parameter int LEN_W    = 10,
    parameter int TICK_DIV = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len_dw,
    output logic             req_ready,
    output logic [TAG_W-1:0] req_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [LEN_W-1:0] cpl_len_dw,
    input  logic [2:0]       cpl_status,
    output logic             cpl_ready,
    output logic             done_valid,
    output logic [TAG_W-1:0] done_tag,
    output logic [1:0]       done_err,
    input  logic             done_ready,
    output logic             err_unexp,
    output logic [TAG_W:0]   outstanding
);

    localparam int NTAGS = 2 ** TAG_W;
    localparam int REM_W = LEN_W + 1;
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [NTAGS-1:0] busy;
    logic [REM_W-1:0] rem [NTAGS];
    logic [1:0]       age [NTAGS];
    logic [PS_W-1:0]  prescaler;

    logic             free_found, tmo_found;
    logic [TAG_W-1:0] free_tag, tmo_tag, retire_tag;
    logic [NTAGS-1:0] tmo_cand;
    logic             alloc, cpl_fire, cpl_hit, cpl_retire, tick, tmo_fire, retire;
    logic [REM_W-1:0] req_len_dec, cpl_len_dec, cpl_rem;
    done_err_e        cpl_err, retire_err;

    tlp_prio_enc #(.W(NTAGS), .IDX_W(TAG_W)) u_free_enc (
        .vec   (~busy),
        .idx   (free_tag),
        .found (free_found)
    );

    tlp_prio_enc #(.W(NTAGS), .IDX_W(TAG_W)) u_tmo_enc (
        .vec   (tmo_cand),
        .idx   (tmo_tag),
        .found (tmo_found)
    );

    assign req_ready = free_found;
    assign req_tag   = free_tag;
    assign cpl_ready = ~done_valid | done_ready;

    always_comb begin
        alloc       = req_valid & free_found;
        cpl_fire    = cpl_valid & cpl_ready;
        cpl_hit     = cpl_fire & busy[cpl_tag];
        req_len_dec = REM_W'(len_decode(16'(req_len_dw), LEN_W));
        cpl_len_dec = REM_W'(len_decode(16'(cpl_len_dw), LEN_W));
        cpl_rem     = rem[cpl_tag];
        cpl_err     = DONE_OK;
        cpl_retire  = 1'b0;
        if (cpl_status != CPL_SC) begin
            cpl_err    = DONE_STAT;
            cpl_retire = cpl_hit;
        end else if (cpl_len_dec > cpl_rem) begin
            cpl_err    = DONE_OVF;
            cpl_retire = cpl_hit;
        end else begin
            cpl_retire = cpl_hit & (cpl_len_dec == cpl_rem);
        end
        tick = (prescaler == PS_W'(TICK_DIV - 1));
        // A tag receiving a completion this cycle is handled as a completion, not a timeout.
        for (int i = 0; i < NTAGS; i++) begin
            tmo_cand[i] = busy[i] & (age[i] == 2'd3) & ~(cpl_hit & (cpl_tag == TAG_W'(i)));
        end
    end

    always_comb begin
        tmo_fire   = tmo_found & cpl_ready & ~cpl_retire;
        retire     = cpl_retire | tmo_fire;
        retire_tag = cpl_retire ? cpl_tag : tmo_tag;
        retire_err = cpl_retire ? cpl_err : DONE_TMO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            prescaler   <= '0;
            done_valid  <= 1'b0;
            done_tag    <= '0;
            done_err    <= DONE_OK;
            err_unexp   <= 1'b0;
            outstanding <= '0;
            // NOTE: the per-tag arrays are flops, not RAM, so they take the reset like any other state.
            for (int i = 0; i < NTAGS; i++) begin
                rem[i] <= '0;
                age[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every read here sees pre-edge state regardless of order.
            prescaler <= tick ? '0 : prescaler + 1'b1;
            err_unexp <= cpl_fire & ~busy[cpl_tag];

            for (int i = 0; i < NTAGS; i++) begin
                if (tick && busy[i] && age[i] != 2'd3) age[i] <= age[i] + 2'd1;
            end
            if (cpl_hit) begin
                rem[cpl_tag] <= cpl_rem - cpl_len_dec;
                age[cpl_tag] <= '0;
            end

            // Retire and alloc never touch the same tag: one is busy, the other free.
            if (retire) busy[retire_tag] <= 1'b0;
            if (alloc) begin
                busy[free_tag] <= 1'b1;
                rem[free_tag]  <= req_len_dec;
                age[free_tag]  <= '0;
            end

            if (retire) begin
                done_valid <= 1'b1;
                done_tag   <= retire_tag;
                done_err   <= retire_err;
            end else if (done_ready) begin
                done_valid <= 1'b0;
            end

            if (alloc && !retire)      outstanding <= outstanding + 1'b1;
            else if (retire && !alloc) outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_tlp_rd_cpl_tracker.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue/array model of the tag tracker.
`timescale 1ns/1ps
module tb_tlp_rd_cpl_tracker;
    import tlp_pkg::*;

    localparam int TAG_W    = 3;
    localparam int LEN_W    = 10;
    localparam int TICK_DIV = 4;
    localparam int NTAGS    = 2 ** TAG_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid;
    logic [LEN_W-1:0] req_len_dw;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic             cpl_valid;
    logic [TAG_W-1:0] cpl_tag;
    logic [LEN_W-1:0] cpl_len_dw;
    logic [2:0]       cpl_status;
    logic             cpl_ready;
    logic             done_valid;
    logic [TAG_W-1:0] done_tag;
    logic [1:0]       done_err;
    logic             done_ready;
    logic             err_unexp;
    logic [TAG_W:0]   outstanding;

    int tests = 0;
    int fails = 0;

    tlp_rd_cpl_tracker #(.TAG_W(TAG_W), .LEN_W(LEN_W), .TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_len_dw  (req_len_dw),
        .req_ready   (req_ready),
        .req_tag     (req_tag),
        .cpl_valid   (cpl_valid),
        .cpl_tag     (cpl_tag),
        .cpl_len_dw  (cpl_len_dw),
        .cpl_status  (cpl_status),
        .cpl_ready   (cpl_ready),
        .done_valid  (done_valid),
        .done_tag    (done_tag),
        .done_err    (done_err),
        .done_ready  (done_ready),
        .err_unexp   (err_unexp),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int tag;
        int err;
    } done_t;

    bit    m_busy  [NTAGS];
    int    m_rem   [NTAGS];
    int    m_ticks [NTAGS];   // age ticks since last progress, saturating at 3
    int    m_phase;
    bit    m_unexp;
    done_t done_q [$];

    task automatic model_reset();
        for (int i = 0; i < NTAGS; i++) begin
            m_busy[i]  = 1'b0;
            m_rem[i]   = 0;
            m_ticks[i] = 0;
        end
        m_phase = 0;
        m_unexp = 1'b0;
        done_q.delete();
    endtask

    task automatic model_step();
        int    fr;
        int    hit;
        int    l;
        int    t;
        bit    crdy;
        bit    have_ev;
        done_t ev;
        crdy = (done_q.size() == 0) || done_ready;
        fr = -1;
        for (int i = 0; i < NTAGS; i++) if (!m_busy[i] && fr < 0) fr = i;
        if (done_q.size() != 0 && done_ready) void'(done_q.pop_front());
        have_ev = 1'b0;
        hit     = -1;
        m_unexp = 1'b0;
        ev      = '{tag: 0, err: 0};
        if (cpl_valid && crdy) begin
            t = int'(cpl_tag);
            if (!m_busy[t]) begin
                m_unexp = 1'b1;
            end else begin
                hit = t;
                l = (cpl_len_dw == 0) ? 1024 : int'(cpl_len_dw);
                if (cpl_status != 3'b000) begin
                    have_ev = 1'b1; ev = '{tag: t, err: 1};
                end else if (l > m_rem[t]) begin
                    have_ev = 1'b1; ev = '{tag: t, err: 2};
                end else begin
                    m_rem[t] -= l;
                    if (m_rem[t] == 0) begin
                        have_ev = 1'b1; ev = '{tag: t, err: 0};
                    end
                end
            end
        end
        if (!have_ev && crdy) begin
            for (int i = NTAGS - 1; i >= 0; i--) begin
                if (m_busy[i] && m_ticks[i] >= 3 && i != hit) begin
                    have_ev = 1'b1; ev = '{tag: i, err: 3};
                end
            end
        end
        if (m_phase == TICK_DIV - 1)
            for (int i = 0; i < NTAGS; i++)
                if (m_busy[i] && m_ticks[i] < 3) m_ticks[i]++;
        if (hit >= 0) m_ticks[hit] = 0;
        m_phase = (m_phase + 1) % TICK_DIV;
        if (have_ev) begin
            m_busy[ev.tag] = 1'b0;
            done_q.push_back(ev);
        end
        if (req_valid && fr >= 0) begin
            m_busy[fr]  = 1'b1;
            m_rem[fr]   = (req_len_dw == 0) ? 1024 : int'(req_len_dw);
            m_ticks[fr] = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare DUT outputs against the model mid-cycle, away from the active edge.
    task automatic compare();
        int fr;
        int cnt;
        fr  = -1;
        cnt = 0;
        for (int i = 0; i < NTAGS; i++) begin
            if (!m_busy[i]) begin
                if (fr < 0) fr = i;
            end else begin
                cnt++;
            end
        end
        check("req_ready", 32'(req_ready), 32'(fr >= 0));
        if (fr >= 0) check("req_tag", 32'(req_tag), 32'(fr));
        check("cpl_ready", 32'(cpl_ready), 32'((done_q.size() == 0) || done_ready));
        check("done_valid", 32'(done_valid), 32'(done_q.size() != 0));
        if (done_q.size() != 0) begin
            check("done_tag", 32'(done_tag), 32'(done_q[0].tag));
            check("done_err", 32'(done_err), 32'(done_q[0].err));
        end
        check("err_unexp", 32'(err_unexp), 32'(m_unexp));
        check("outstanding", 32'(outstanding), 32'(cnt));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) compare();
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        cpl_valid = 1'b0;
        done_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic do_req(input int len);
        req_valid  = 1'b1;
        req_len_dw = LEN_W'(len);
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic do_cpl(input int tag, input int len, input logic [2:0] st);
        cpl_valid  = 1'b1;
        cpl_tag    = TAG_W'(tag);
        cpl_len_dw = LEN_W'(len);
        cpl_status = st;
        tick();
        cpl_valid  = 1'b0;
    endtask

    initial begin
        int n;
        int busy_list [$];
        int t;
        int rm;
        int r;
        req_valid = 1'b0; req_len_dw = '0;
        cpl_valid = 1'b0; cpl_tag = '0; cpl_len_dw = '0; cpl_status = '0;
        done_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_req_tag", 32'(req_tag), 0);
        check("rst_cpl_ready", 32'(cpl_ready), 1);
        check("rst_done_valid", 32'(done_valid), 0);
        check("rst_err_unexp", 32'(err_unexp), 0);
        check("rst_outstanding", 32'(outstanding), 0);

        // Single request, single final completion
        req_valid = 1'b1; req_len_dw = 10'd4;
        check("t1_req_tag", 32'(req_tag), 0);
        tick();
        req_valid = 1'b0;
        check("t1_out_one", 32'(outstanding), 1);
        do_cpl(0, 4, CPL_SC);
        check("t1_done_valid", 32'(done_valid), 1);
        check("t1_done_tag", 32'(done_tag), 0);
        check("t1_done_err", 32'(done_err), 0);
        check("t1_out_zero", 32'(outstanding), 0);
        tick();
        check("t1_done_clear", 32'(done_valid), 0);

        // Fill all tags, then free tag 5
        do_reset();
        for (int i = 0; i < NTAGS; i++) begin
            req_valid = 1'b1; req_len_dw = 10'd2;
            check("t2_req_ready", 32'(req_ready), 1);
            check("t2_req_tag", 32'(req_tag), 32'(i));
            tick();
        end
        check("t2_full_ready", 32'(req_ready), 0);
        tick();
        req_valid = 1'b0;
        check("t2_out_full", 32'(outstanding), 8);
        do_cpl(5, 1, CPL_UR);
        check("t2_freed_ready", 32'(req_ready), 1);
        check("t2_freed_tag", 32'(req_tag), 5);
        check("t2_done_tag", 32'(done_tag), 5);
        check("t2_done_err", 32'(done_err), 1);

        // Split completions and the 1024-DW encoding
        do_reset();
        do_req(16);
        do_cpl(0, 8, CPL_SC);
        check("t3_no_done_half", 32'(done_valid), 0);
        do_cpl(0, 8, CPL_SC);
        check("t3_done_valid", 32'(done_valid), 1);
        check("t3_done_err", 32'(done_err), 0);
        check("t3_reuse_tag", 32'(req_tag), 0);
        do_req(0);
        for (int i = 0; i < 32; i++) begin
            do_cpl(0, 32, CPL_SC);
            if (i < 31) check("t3_no_early_done", 32'(done_valid), 0);
        end
        check("t3_1024_done", 32'(done_valid), 1);
        check("t3_1024_err", 32'(done_err), 0);

        // Unexpected tag, overflow, bad status
        do_reset();
        do_cpl(3, 1, CPL_SC);
        check("t4_unexp_pulse", 32'(err_unexp), 1);
        check("t4_unexp_nodone", 32'(done_valid), 0);
        tick();
        check("t4_unexp_once", 32'(err_unexp), 0);
        check("t4_unexp_nodone2", 32'(done_valid), 0);
        do_req(8);
        do_cpl(0, 9, CPL_SC);
        check("t4_ovf_valid", 32'(done_valid), 1);
        check("t4_ovf_err", 32'(done_err), 2);
        do_req(8);
        do_cpl(0, 1, CPL_UR);
        check("t4_stat_err", 32'(done_err), 1);
        do_req(8);
        do_cpl(0, 1, CPL_CA);
        check("t4_ca_err", 32'(done_err), 1);

        // Timeout, and completion on the timeout cycle
        do_reset();
        do_req(4);
        n = 0;
        while (!done_valid && n < 40) begin
            tick();
            n++;
        end
        check("t5_tmo_seen", 32'(done_valid), 1);
        check("t5_tmo_err", 32'(done_err), 3);
        check("t5_tmo_window", 32'(n >= 9 && n <= 16), 1);
        do_reset();
        do_req(8);
        n = 0;
        while (m_ticks[0] < 3 && n < 40) begin
            tick();
            n++;
        end
        check("t5_cand_reached", 32'(m_ticks[0]), 3);
        do_cpl(0, 8, CPL_SC);
        check("t5_race_valid", 32'(done_valid), 1);
        check("t5_race_err", 32'(done_err), 0);
        tick();
        check("t5_race_single", 32'(done_valid), 0);

        // Back-pressure on the done register
        do_reset();
        do_req(1);
        do_req(1);
        done_ready = 1'b0;
        do_cpl(0, 1, CPL_SC);
        check("t6_first_tag", 32'(done_tag), 0);
        check("t6_cpl_blocked", 32'(cpl_ready), 0);
        cpl_valid = 1'b1; cpl_tag = 3'd1; cpl_len_dw = 10'd1; cpl_status = CPL_SC;
        repeat (3) begin
            tick();
            check("t6_held_tag", 32'(done_tag), 0);
            check("t6_held_block", 32'(cpl_ready), 0);
        end
        done_ready = 1'b1;
        tick();
        cpl_valid = 1'b0;
        check("t6_second_valid", 32'(done_valid), 1);
        check("t6_second_tag", 32'(done_tag), 1);
        check("t6_second_err", 32'(done_err), 0);
        tick();
        check("t6_drained", 32'(done_valid), 0);
        check("t6_out_zero", 32'(outstanding), 0);

        // Random traffic against the model, with one reset mid-stream
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                req_valid = 1'b0;
                cpl_valid = 1'b0;
                tick();
                check("rnd_reset_out", 32'(outstanding), 0);
                check("rnd_reset_done", 32'(done_valid), 0);
            end
            req_valid = ($urandom_range(0, 99) < 40);
            r = $urandom_range(0, 99);
            if (r < 5)       req_len_dw = '0;
            else if (r < 10) req_len_dw = LEN_W'($urandom);
            else             req_len_dw = LEN_W'($urandom_range(1, 16));
            busy_list.delete();
            for (int i = 0; i < NTAGS; i++) if (m_busy[i]) busy_list.push_back(i);
            cpl_valid = ($urandom_range(0, 99) < 55);
            if (busy_list.size() != 0 && $urandom_range(0, 99) < 85)
                t = busy_list[$urandom_range(0, busy_list.size() - 1)];
            else
                t = $urandom_range(0, NTAGS - 1);
            cpl_tag = TAG_W'(t);
            rm = m_busy[t] ? m_rem[t] : 16;
            r = $urandom_range(0, 99);
            if (r < 6 && rm < 1023) cpl_len_dw = LEN_W'(rm + 1);
            else if (r < 25)        cpl_len_dw = LEN_W'(rm);
            else                    cpl_len_dw = LEN_W'($urandom_range(1, (rm > 16) ? 16 : rm));
            if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 2))
                    0:       cpl_status = CPL_UR;
                    1:       cpl_status = CPL_CRS;
                    default: cpl_status = CPL_CA;
                endcase
            end else begin
                cpl_status = CPL_SC;
            end
            done_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        req_valid = 1'b0;
        cpl_valid = 1'b0;
        done_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
